multicycle_control: RTL and testbench

Sequencing controller for the multicycle MIPS datapath: one shared instruction/data memory, one ALU, and the IR/A/B/ALUOut/MDR holding registers. A Moore FSM steps each instruction through fetch, decode, execute, memory and write-back. It waits on a memory-ready handshake and drives every datapath mux, write-enable and ALU operation. It replaces the single-cycle decoder and keeps the same instruction set and ALUOp encoding.

---
 rtl/multicycle_control_pkg.sv | 70 +++++++
 rtl/multicycle_control_if.sv | 25 ++
 rtl/multicycle_control_instr_class_decode.sv | 43 ++++
 rtl/multicycle_control.sv | 137 +++++++++++++
 tb/tb_multicycle_control.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multicycle MIPS sequencing controller.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_ALUWB, S_BRANCH, S_JUMP, S_JR, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        CLS_MEM, CLS_ALU_R, CLS_ALU_I, CLS_BRANCH, CLS_JUMP, CLS_JR, CLS_ILLEGAL
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_LUI = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1001;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_A     = 2'd1;
    localparam logic [1:0] SRCA_SHAMT = 2'd2;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_4      = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JR     = 2'd2;
    localparam logic [1:0] PCSRC_JUMP   = 2'd3;

    typedef struct packed {
        iclass_t    cls;
        logic [3:0] alu_op;
        logic       is_shift;
        logic       is_store;
        logic       is_bne;
        logic       is_jal;
        logic       sign_ext;
    } decode_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: IR fields and flags in, mux selects and enables out.
interface multicycle_control_if;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, IorD, IRWrite, MemRead, MemWrite;
    logic       MemtoReg, RegDst, Jal, RegWrite, ExtFormat;
    logic [1:0] ALUSrcA, ALUSrcB;
    logic [3:0] ALUOp;
    logic [1:0] PCSource;
    logic       BadInstr;

    modport master (
        input  Opcode, Funct, Zero, MemReady,
        output PCWrite, IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegDst,
               Jal, RegWrite, ExtFormat, ALUSrcA, ALUSrcB, ALUOp, PCSource, BadInstr
    );

    modport slave (
        output Opcode, Funct, Zero, MemReady,
        input  PCWrite, IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegDst,
               Jal, RegWrite, ExtFormat, ALUSrcA, ALUSrcB, ALUOp, PCSource, BadInstr
    );
endinterface

// File: rtl/multicycle_control_instr_class_decode.sv
// Combinational opcode/funct classifier; also yields the EXEC-stage ALU operation.
module instr_class_decode
    import multicycle_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output decode_t    dec
);
    always_comb begin
        dec        = '0;
        dec.cls    = CLS_ILLEGAL;
        dec.alu_op = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                dec.cls = CLS_ALU_R;
                case (funct)
                    FN_ADD: dec.alu_op = ALU_ADD;
                    FN_SUB: dec.alu_op = ALU_SUB;
                    FN_AND: dec.alu_op = ALU_AND;
                    FN_OR:  dec.alu_op = ALU_OR;
                    FN_XOR: dec.alu_op = ALU_XOR;
                    FN_SLL: begin dec.alu_op = ALU_SLL; dec.is_shift = 1'b1; end
                    FN_SRL: begin dec.alu_op = ALU_SRL; dec.is_shift = 1'b1; end
                    FN_SRA: begin dec.alu_op = ALU_SRA; dec.is_shift = 1'b1; end
                    FN_JR:  dec.cls = CLS_JR;
                    default: dec.cls = CLS_ILLEGAL;
                endcase
            end
            OP_LW:   dec.cls = CLS_MEM;
            OP_SW:   begin dec.cls = CLS_MEM; dec.is_store = 1'b1; end
            OP_ADDI: begin dec.cls = CLS_ALU_I; dec.alu_op = ALU_ADD; dec.sign_ext = 1'b1; end
            OP_ANDI: begin dec.cls = CLS_ALU_I; dec.alu_op = ALU_AND; end
            OP_ORI:  begin dec.cls = CLS_ALU_I; dec.alu_op = ALU_OR;  end
            OP_XORI: begin dec.cls = CLS_ALU_I; dec.alu_op = ALU_XOR; end
            OP_LUI:  begin dec.cls = CLS_ALU_I; dec.alu_op = ALU_LUI; end
            OP_BEQ:  dec.cls = CLS_BRANCH;
            OP_BNE:  begin dec.cls = CLS_BRANCH; dec.is_bne = 1'b1; end
            OP_J:    dec.cls = CLS_JUMP;
            OP_JAL:  begin dec.cls = CLS_JUMP; dec.is_jal = 1'b1; end
            default: dec.cls = CLS_ILLEGAL;
        endcase
    end
endmodule

// File: rtl/multicycle_control.sv
// Moore sequencing FSM for the multicycle MIPS datapath. Outputs are a pure function of
// state, except the FETCH enables (MemReady) and BRANCH PCWrite (Zero).
module multicycle_control
    import multicycle_pkg::*;
(
    input logic                 clk,
    input logic                 rst,
    multicycle_control_if.master bus
);
    state_t  state, next;
    decode_t dec;

    instr_class_decode u_dec (
        .opcode (bus.Opcode),
        .funct  (bus.Funct),
        .dec    (dec)
    );

    // Async reset lands in IDLE, whose outputs are all zero, so an aborted
    // instruction cannot fire a write-enable in the reset cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next;
    end

    always_comb begin
        next          = state;
        bus.PCWrite   = 1'b0;
        bus.IorD      = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.MemtoReg  = 1'b0;
        bus.RegDst    = 1'b0;
        bus.Jal       = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.ExtFormat = 1'b0;
        bus.ALUSrcA   = SRCA_PC;
        bus.ALUSrcB   = SRCB_B;
        bus.ALUOp     = ALU_AND;
        bus.PCSource  = PCSRC_ALU;
        bus.BadInstr  = 1'b0;
        case (state)
            S_IDLE: next = S_FETCH;
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = SRCB_4;
                bus.ALUOp   = ALU_ADD;
                if (bus.MemReady) begin
                    bus.IRWrite = 1'b1;
                    bus.PCWrite = 1'b1;
                    next        = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculatively form the branch target into ALUOut.
                bus.ALUSrcB   = SRCB_IMM_SH;
                bus.ALUOp     = ALU_ADD;
                bus.ExtFormat = 1'b1;
                case (dec.cls)
                    CLS_MEM:              next = S_MEMADR;
                    CLS_ALU_R, CLS_ALU_I: next = S_EXEC;
                    CLS_BRANCH:           next = S_BRANCH;
                    CLS_JUMP:             next = S_JUMP;
                    CLS_JR:               next = S_JR;
                    default:              next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA   = SRCA_A;
                bus.ALUSrcB   = SRCB_IMM;
                bus.ExtFormat = 1'b1;
                bus.ALUOp     = ALU_ADD;
                next          = dec.is_store ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                if (bus.MemReady) next = S_MEMWB;
            end
            S_MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
                bus.MemtoReg = 1'b1;
                next         = S_FETCH;
            end
            S_MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
                if (bus.MemReady) next = S_FETCH;
            end
            S_EXEC: begin
                bus.ALUOp = dec.alu_op;
                if (dec.cls == CLS_ALU_R) begin
                    bus.ALUSrcA = dec.is_shift ? SRCA_SHAMT : SRCA_A;
                    bus.ALUSrcB = SRCB_B;
                end else begin
                    bus.ALUSrcA   = SRCA_A;
                    bus.ALUSrcB   = SRCB_IMM;
                    bus.ExtFormat = dec.sign_ext;
                end
                next = S_ALUWB;
            end
            S_ALUWB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = (dec.cls == CLS_ALU_I);
                next         = S_FETCH;
            end
            S_BRANCH: begin
                bus.ALUSrcA  = SRCA_A;
                bus.ALUSrcB  = SRCB_B;
                bus.ALUOp    = ALU_SUB;
                bus.PCSource = PCSRC_ALUOUT;
                bus.PCWrite  = dec.is_bne ? ~bus.Zero : bus.Zero;
                next         = S_FETCH;
            end
            S_JUMP: begin
                // PC already holds PC+4 from FETCH, which is the jal link value.
                bus.PCWrite  = 1'b1;
                bus.PCSource = PCSRC_JUMP;
                bus.RegWrite = dec.is_jal;
                bus.Jal      = dec.is_jal;
                next         = S_FETCH;
            end
            S_JR: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = PCSRC_JR;
                next         = S_FETCH;
            end
            S_TRAP: begin
                bus.BadInstr = 1'b1;
                next         = S_TRAP;
            end
            default: next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: walks each instruction class through the FSM and checks every output per cycle.
module tb_multicycle_control;

    typedef struct packed {
        logic       PCWrite, IorD, IRWrite, MemRead, MemWrite;
        logic       MemtoReg, RegDst, Jal, RegWrite, ExtFormat;
        logic [1:0] ALUSrcA, ALUSrcB;
        logic [3:0] ALUOp;
        logic [1:0] PCSource;
        logic       BadInstr;
    } ctl_t;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    ctl_t obs;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign obs = '{PCWrite: bus.PCWrite, IorD: bus.IorD, IRWrite: bus.IRWrite,
                   MemRead: bus.MemRead, MemWrite: bus.MemWrite, MemtoReg: bus.MemtoReg,
                   RegDst: bus.RegDst, Jal: bus.Jal, RegWrite: bus.RegWrite,
                   ExtFormat: bus.ExtFormat, ALUSrcA: bus.ALUSrcA, ALUSrcB: bus.ALUSrcB,
                   ALUOp: bus.ALUOp, PCSource: bus.PCSource, BadInstr: bus.BadInstr};

    // Hand-written expected output vectors, one per FSM state.
    function automatic ctl_t e_idle();
        ctl_t c = '0;
        return c;
    endfunction

    function automatic ctl_t e_fetch(input logic rdy);
        ctl_t c = '0;
        c.MemRead = 1'b1; c.ALUSrcB = 2'd1; c.ALUOp = 4'b0010;
        c.IRWrite = rdy;  c.PCWrite = rdy;
        return c;
    endfunction

    function automatic ctl_t e_decode();
        ctl_t c = '0;
        c.ALUSrcB = 2'd3; c.ALUOp = 4'b0010; c.ExtFormat = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_memadr();
        ctl_t c = '0;
        c.ALUSrcA = 2'd1; c.ALUSrcB = 2'd2; c.ExtFormat = 1'b1; c.ALUOp = 4'b0010;
        return c;
    endfunction

    function automatic ctl_t e_mem(input logic wr);
        ctl_t c = '0;
        c.IorD = 1'b1; c.MemRead = ~wr; c.MemWrite = wr;
        return c;
    endfunction

    function automatic ctl_t e_wb(input logic frommem, input logic rt);
        ctl_t c = '0;
        c.RegWrite = 1'b1; c.MemtoReg = frommem; c.RegDst = rt;
        return c;
    endfunction

    function automatic ctl_t e_exec(input logic [1:0] sa, input logic [1:0] sb,
                                    input logic [3:0] op, input logic ext);
        ctl_t c = '0;
        c.ALUSrcA = sa; c.ALUSrcB = sb; c.ALUOp = op; c.ExtFormat = ext;
        return c;
    endfunction

    function automatic ctl_t e_branch(input logic pcw);
        ctl_t c = '0;
        c.ALUSrcA = 2'd1; c.ALUOp = 4'b0110; c.PCSource = 2'd1; c.PCWrite = pcw;
        return c;
    endfunction

    function automatic ctl_t e_jump(input logic [1:0] src, input logic link);
        ctl_t c = '0;
        c.PCWrite = 1'b1; c.PCSource = src; c.RegWrite = link; c.Jal = link;
        return c;
    endfunction

    function automatic ctl_t e_trap();
        ctl_t c = '0;
        c.BadInstr = 1'b1;
        return c;
    endfunction

    task automatic chk(input string tag, input ctl_t exp);
        #1;
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] fn);
        bus.Opcode = op;
        bus.Funct  = fn;
    endtask

    initial begin
        rst = 1'b1;
        bus.Opcode = 6'h00; bus.Funct = 6'h20; bus.Zero = 1'b0; bus.MemReady = 1'b1;
        chk("reset_held", e_idle());
        @(posedge clk); #1;
        rst = 1'b0;
        chk("idle_after_release", e_idle());

        // add: FETCH DECODE EXEC ALUWB, back in FETCH at cycle 5
        step(); chk("add_fetch", e_fetch(1'b1));
        step(); chk("add_decode", e_decode());
        step(); chk("add_exec", e_exec(2'd1, 2'd0, 4'b0010, 1'b0));
        step(); chk("add_aluwb", e_wb(1'b0, 1'b0));
        step(); instr(6'h23, 6'h00); chk("lw_fetch", e_fetch(1'b1));

        // lw with two wait cycles in MEMRD
        step(); chk("lw_decode", e_decode());
        step(); chk("lw_memadr", e_memadr());
        step(); bus.MemReady = 1'b0; chk("lw_memrd0", e_mem(1'b0));
        step(); chk("lw_memrd1", e_mem(1'b0));
        step(); bus.MemReady = 1'b1; chk("lw_memrd2", e_mem(1'b0));
        step(); chk("lw_memwb", e_wb(1'b1, 1'b1));

        // beq Zero=1, with one FETCH wait cycle first
        step(); instr(6'h04, 6'h00); bus.Zero = 1'b1; bus.MemReady = 1'b0;
        chk("beq_fetch_wait", e_fetch(1'b0));
        step(); bus.MemReady = 1'b1; chk("beq_fetch", e_fetch(1'b1));
        step(); chk("beq_decode", e_decode());
        step(); chk("beq_taken", e_branch(1'b1));

        // bne Zero=1 (not taken) then Zero=0 (taken)
        step(); instr(6'h05, 6'h00); chk("bne_fetch", e_fetch(1'b1));
        step(); chk("bne_decode", e_decode());
        step(); chk("bne_not_taken", e_branch(1'b0));
        step(); chk("bne2_fetch", e_fetch(1'b1));
        step(); bus.Zero = 1'b0; chk("bne2_decode", e_decode());
        step(); chk("bne_taken", e_branch(1'b1));

        // jal, j, jr
        step(); instr(6'h03, 6'h00); chk("jal_fetch", e_fetch(1'b1));
        step(); chk("jal_decode", e_decode());
        step(); chk("jal_jump", e_jump(2'd3, 1'b1));
        step(); instr(6'h02, 6'h00); chk("j_fetch", e_fetch(1'b1));
        step(); step(); chk("j_jump", e_jump(2'd3, 1'b0));
        step(); instr(6'h00, 6'h08); chk("jr_fetch", e_fetch(1'b1));
        step(); chk("jr_decode", e_decode());
        step(); chk("jr_jr", e_jump(2'd2, 1'b0));

        // shifts and I-type extension format
        step(); instr(6'h00, 6'h00); step();
        step(); chk("sll_exec", e_exec(2'd2, 2'd0, 4'b0100, 1'b0));
        step(); chk("sll_aluwb", e_wb(1'b0, 1'b0));
        step(); instr(6'h00, 6'h03); step();
        step(); chk("sra_exec", e_exec(2'd2, 2'd0, 4'b1001, 1'b0));
        step(); step(); instr(6'h08, 6'h00); step();
        step(); chk("addi_exec", e_exec(2'd1, 2'd2, 4'b0010, 1'b1));
        step(); chk("addi_aluwb", e_wb(1'b0, 1'b1));
        step(); instr(6'h0d, 6'h00); step();
        step(); chk("ori_exec", e_exec(2'd1, 2'd2, 4'b0001, 1'b0));
        step(); chk("ori_aluwb", e_wb(1'b0, 1'b1));

        // illegal opcode traps and stays trapped regardless of MemReady
        step(); instr(6'h3f, 6'h00); chk("bad_fetch", e_fetch(1'b1));
        step(); chk("bad_decode", e_decode());
        step(); chk("trap0", e_trap());
        step(); bus.MemReady = 1'b0; chk("trap1", e_trap());
        step(); bus.MemReady = 1'b1; chk("trap2", e_trap());

        rst = 1'b1; chk("trap_reset", e_idle());
        rst = 1'b0; chk("trap_release", e_idle());

        // sw, abort with rst while waiting in MEMWR
        step(); instr(6'h2b, 6'h00); chk("sw_fetch", e_fetch(1'b1));
        step(); chk("sw_decode", e_decode());
        step(); chk("sw_memadr", e_memadr());
        step(); bus.MemReady = 1'b0; chk("sw_memwr_wait", e_mem(1'b1));
        step(); chk("sw_memwr_hold", e_mem(1'b1));
        rst = 1'b1; chk("sw_abort_reset", e_idle());
        rst = 1'b0; bus.MemReady = 1'b1; chk("sw_abort_release", e_idle());
        step(); chk("restart_fetch", e_fetch(1'b1));
        step(); chk("restart_decode", e_decode());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
